// File: rtl/shift_out_reg.sv
// -----------------------------------------------------------------------------
// shift_out_reg
//
// Parallel-to-serial unload register. A WIDTH-bit word is captured on a load
// strobe and then drained one bit per accepted beat over a valid/ready serial
// interface. A one-cycle done pulse follows the final accepted bit.
//
// Build option:
//   SHIFT_MSB_FIRST_EN  - when defined, bits leave MSB first (first bit out is
//                         d[WIDTH-1]); otherwise LSB first. Handshake, timing,
//                         last and done behave identically in both builds.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset (highest priority)
//   ld     in   load strobe; captures d when idle
//   d      in   [WIDTH-1:0] parallel word to transmit
//   ready  in   consumer accepts the current bit this cycle
//   sout   out  current serial bit
//   sval   out  sout is valid
//   last   out  current bit is the final bit of the word
//   busy   out  word in flight; ld ignored
//   done   out  one-cycle pulse after the final bit is accepted
//
// All outputs are decoded from registered state only; no input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module shift_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             ready,
    output logic             sout,
    output logic             sval,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             at_last;

    assign at_last = (cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. ld is only honoured from IDLE, so a word in flight
    // (and the DONE cycle after it) can never be overwritten.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ld) state_next = SHIFT;
            SHIFT:   if (ready && at_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Data path: capture on load, shift on each accepted non-final beat.
    // The final beat leaves shreg alone; sout is masked outside SHIFT anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld) begin
                        shreg <= d;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (ready && !at_last) begin
`ifdef SHIFT_MSB_FIRST_EN
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
`else
                        shreg <= {1'b0, shreg[WIDTH-1:1]};
`endif
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state.
    always_comb begin
        sval = (state == SHIFT);
        busy = (state == SHIFT);
        done = (state == DONE);
        last = (state == SHIFT) && at_last;
`ifdef SHIFT_MSB_FIRST_EN
        sout = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
`else
        sout = (state == SHIFT) ? shreg[0] : 1'b0;
`endif
    end

endmodule

// File: tb/tb_shift_out_reg.sv
// -----------------------------------------------------------------------------
// tb_shift_out_reg
//
// Bench for shift_out_reg at WIDTH=8. A behavioural model holds the word in
// flight as a queue of bits still to be sent plus a done flag; every cycle the
// DUT outputs are compared against it. Directed transfers reconstruct the
// accepted bit stream into a word and compare it with hand-written values.
// -----------------------------------------------------------------------------
module tb_shift_out_reg;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             ld;
    logic [WIDTH-1:0] d;
    logic             ready;
    logic             sout;
    logic             sval;
    logic             last;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    shift_out_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .ld    (ld),
        .d     (d),
        .ready (ready),
        .sout  (sout),
        .sval  (sval),
        .last  (last),
        .busy  (busy),
        .done  (done)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared comparison routine; every check steps the same counters.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive all inputs at once (caller chooses the edge).
    task automatic applyStimulus(input logic l, input logic [WIDTH-1:0] dv, input logic r, input logic rs);
        ld    = l;
        d     = dv;
        ready = r;
        rst   = rs;
    endtask

    // Behavioural model: bits still to be sent, in transmission order, plus a
    // flag for the single done cycle that follows the final accepted bit.
    bit q[$];
    bit doneFlag   = 1'b0;
    bit modelValid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            doneFlag   = 1'b0;
            modelValid = 1'b1;
        end else if (doneFlag) begin
            doneFlag = 1'b0;
        end else if (q.size() == 0) begin
            if (ld) begin
                for (int i = 0; i < WIDTH; i++) begin
`ifdef SHIFT_MSB_FIRST_EN
                    q.push_back(d[WIDTH-1-i]);
`else
                    q.push_back(d[i]);
`endif
                end
            end
        end else if (ready) begin
            void'(q.pop_front());
            if (q.size() == 0) doneFlag = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("sval", {31'd0, sval}, {31'd0, q.size() > 0});
            checkOutput("busy", {31'd0, busy}, {31'd0, q.size() > 0});
            checkOutput("last", {31'd0, last}, {31'd0, q.size() == 1});
            checkOutput("done", {31'd0, done}, {31'd0, doneFlag});
            checkOutput("sout", {31'd0, sout}, {31'd0, (q.size() > 0) ? q[0] : 1'b0});
        end
    end

    // Runs one directed transfer and rebuilds the accepted bits into a word in
    // the original bit positions. injectAt/resetAt (1-based sval cycle, or 0)
    // add a stray load of 8'hFF or a reset during the transfer.
    task automatic sendWord(input logic [WIDTH-1:0] word, input bit toggleReady,
                            input int injectAt, input int resetAt,
                            output logic [WIDTH-1:0] got, output int svalCycles,
                            output int doneCount);
        int idx      = 0;
        bit rdy;
        bit rstIssued = 1'b0;
        bit finished  = 1'b0;
        got        = '0;
        svalCycles = 0;
        doneCount  = 0;
        @(negedge clk);
        applyStimulus(1'b1, word, 1'b1, 1'b0);
        for (int c = 0; c < 200 && !finished; c++) begin
            @(negedge clk);
            applyStimulus(1'b0, WIDTH'($urandom), 1'b1, 1'b0);
            if (rstIssued) begin
                checkOutput("after_rst_sval", {31'd0, sval}, 32'd0);
                checkOutput("after_rst_done", {31'd0, done}, 32'd0);
                finished = 1'b1;
            end else if (done) begin
                doneCount++;
                finished = 1'b1;
            end else if (sval) begin
                svalCycles++;
                rdy   = toggleReady ? (svalCycles % 2 == 1) : 1'b1;
                ready = rdy;
                if (svalCycles == injectAt) begin
                    ld = 1'b1;
                    d  = 8'hFF;
                end
                if (svalCycles == resetAt) begin
                    rst       = 1'b1;
                    rstIssued = 1'b1;
                end else if (rdy && idx < WIDTH) begin
`ifdef SHIFT_MSB_FIRST_EN
                    got[WIDTH-1-idx] = sout;
`else
                    got[idx] = sout;
`endif
                    idx++;
                end
            end
        end
        if (!finished) begin
            errors++;
            checks++;
            $display("[TB] FAIL sendWord_timeout: got no completion expected done within 200 cycles");
        end
        // Watch a few idle cycles so a stray second done is caught.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            if (done) doneCount++;
        end
    endtask

    logic [WIDTH-1:0] got;
    int               nSval;
    int               nDone;

    initial begin
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("reset_sval", {31'd0, sval}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_sout", {31'd0, sout}, 32'd0);
        checkOutput("reset_last", {31'd0, last}, 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // A5 with ready tied high.
        sendWord(8'hA5, 1'b0, 0, 0, got, nSval, nDone);
        checkOutput("a5_word", {24'd0, got}, 32'hA5);
        checkOutput("a5_sval_cycles", nSval, 32'd8);
        checkOutput("a5_done_count", nDone, 32'd1);

        // A5 with ready toggling: each bit held while ready is low.
        sendWord(8'hA5, 1'b1, 0, 0, got, nSval, nDone);
        checkOutput("a5tog_word", {24'd0, got}, 32'hA5);
        checkOutput("a5tog_sval_cycles", nSval, 32'd15);
        checkOutput("a5tog_done_count", nDone, 32'd1);

        // Stray load of FF on cycle 3 of a 0F transfer is ignored.
        sendWord(8'h0F, 1'b0, 3, 0, got, nSval, nDone);
        checkOutput("inject_word", {24'd0, got}, 32'h0F);
        checkOutput("inject_done_count", nDone, 32'd1);

        // Reset on cycle 4 kills the transfer with no done pulse.
        sendWord(8'h3C, 1'b0, 0, 4, got, nSval, nDone);
        checkOutput("rst_done_count", nDone, 32'd0);

        // Fresh word after the reset.
        sendWord(8'h81, 1'b0, 0, 0, got, nSval, nDone);
        checkOutput("w81_word", {24'd0, got}, 32'h81);
        checkOutput("w81_done_count", nDone, 32'd1);

`ifdef SHIFT_MSB_FIRST_EN
        sendWord(8'h01, 1'b0, 0, 0, got, nSval, nDone);
        checkOutput("msb01_word", {24'd0, got}, 32'h01);
        checkOutput("msb01_sval_cycles", nSval, 32'd8);
`endif

        // ld and rst together: reset wins, stays idle.
        @(negedge clk);
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("ldrst_sval", {31'd0, sval}, 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("ldrst_sval_after", {31'd0, sval}, 32'd0);

        // Randomized traffic checked by the per-cycle model compare.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            applyStimulus(($urandom_range(0, 3) == 0), WIDTH'($urandom),
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
        end
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        repeat (WIDTH + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_out_reg.md
Name: shift_out_reg

Overview:
Parallel-to-serial unload register: the reader end of the data path's load registers.
- Captures a WIDTH-bit word on a load strobe and drains it one bit per accepted beat over a valid/ready serial interface.
- Pulses done when the word has fully drained.
- Sits between data-path registers (source of d) and a bit-serial consumer (display/shift chain/serial link).

Parameters:
WIDTH, 32, word width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
ld  input  1  load strobe; captures d when accepted
d  input  WIDTH  parallel word to transmit
ready  input  1  consumer accepts current bit this cycle
sout  output  1  current serial bit
sval  output  1  sout is valid
last  output  1  current bit is the final bit of the word
busy  output  1  word in flight; ld ignored
done  output  1  one-cycle pulse after final bit accepted

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; shift register, bit counter, sout, sval, last, busy and done all 0.
  - rst has priority over every other input.
  - rst mid-transfer discards the in-flight word; no done pulse.
- No combinational path from any input to any output. All outputs are decoded from registered state and data only.
- State IDLE:
  - busy=0, sval=0.
  - ld=1 at edge N: shreg<=d, cnt<=0, state->SHIFT.
  - Cycle N+1: sval=1, busy=1, sout=bit 0 of the captured word (1-cycle load latency).
- State SHIFT:
  - sval=1, busy=1, sout=shreg[0].
  - ready=0: hold sout, sval and cnt unchanged indefinitely.
  - ready=1 and cnt<WIDTH-1: shreg shifts right by 1, cnt<=cnt+1.
  - last=1 exactly when cnt==WIDTH-1.
  - ready=1 with last=1: state->DONE; sval drops the next cycle.
- State DONE:
  - lasts exactly one cycle; done=1, busy=0, sval=0; then state->IDLE.
  - ld asserted in DONE is ignored.
- ld while busy=1 is ignored; the captured word is never overwritten mid-transfer.
- A full transfer with ready tied high takes WIDTH cycles of sval plus 1 done cycle. The earliest next ld is in the cycle after done, giving a minimum period of WIDTH+2 cycles.
- Counter width: clog2(WIDTH) bits. The counter never wraps in normal operation and is cleared on each load.
- d is sampled only at the accepting edge. Later changes to d do not affect the transfer.

Optional Feature:
Macro SHIFT_MSB_FIRST_EN.
- Defined: bit order is MSB first.
  - sout=shreg[WIDTH-1]; shift left on each accepted beat.
  - First bit out is d[WIDTH-1].
- Not defined (default): LSB first, as described above.
- Handshake, timing, last and done are identical in both builds.

Test Plan:
- WIDTH=8, ready=1, ld pulse with d=8'hA5 → from the cycle after ld, sout=1,0,1,0,0,1,0,1 over 8 cycles with sval=1. last=1 only on the 8th bit. done=1 on cycle 9. busy back to 0 on cycle 9.
- Same word with ready toggling 1,0,1,0… → each bit is held while ready=0. 8 accepted beats occupy 15 cycles. Bit sequence is unchanged and done fires once.
- Second ld with d=8'hFF issued on cycle 3 of a transfer of 8'h0F → ignored. Output sequence is still 1,1,1,1,0,0,0,0.
- rst=1 on cycle 4 of a transfer → next cycle all outputs are 0 and no done pulse. A fresh ld with d=8'h81 then transmits 1,0,0,0,0,0,0,1 correctly.
- ld and rst asserted together with d=8'hAA → remains IDLE with sval=0.
- SHIFT_MSB_FIRST_EN defined, d=8'hA5, ready=1 → sout=1,0,1,0,0,1,0,1 (A5 is a bit-palindrome). Then d=8'h01 → sout=0,0,0,0,0,0,0,1 with last=1 on the final 1.
